// File: rtl/vend_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module   : vend_ctrl_n
//  Purpose  : Multi-product coffee vending controller. Accumulates coin
//             credit, latches a product selection, compares credit against a
//             per-product price table and runs a request/acknowledge
//             handshake with the dispenser. Cancel refunds the credit.
//  Option   : VEND_CHANGE_EN - when defined, residual credit after a sale is
//             returned as change; otherwise it is carried into the next sale.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl_n #(
  parameter int N_PROD = 4,
  parameter int SUM_W  = 6,
  parameter int COIN_W = 4,
  parameter logic [N_PROD*SUM_W-1:0] PRICES = {6'd10, 6'd5, 6'd1, 6'd2},
  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid_i,
  input  logic [COIN_W-1:0] coin_val_i,
  input  logic             sel_valid_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             cancel_i,
  input  logic             disp_ack_i,
  output logic             disp_req_o,
  output logic [SEL_W-1:0] disp_prod_o,
  output logic             change_valid_o,
  output logic [SUM_W-1:0] change_amt_o,
  output logic             coin_reject_o,
  output logic [SUM_W-1:0] credit_o,
  output logic             led_green_o,
  output logic             led_yellow_o
);

  // Sums are formed one bit wider than the wider operand so that an
  // overflowing coin can be detected rather than silently wrapping.
  localparam int CALC_W     = ((SUM_W > COIN_W) ? SUM_W : COIN_W) + 1;
  localparam int MAX_CREDIT = (1 << SUM_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t             state_q;
  logic [SUM_W-1:0]   credit_q;
  logic [SEL_W-1:0]   sel_q;
  logic               sel_vld_q;
  logic               disp_req_q;
  logic [SEL_W-1:0]   disp_prod_q;
  logic               change_valid_q;
  logic [SUM_W-1:0]   change_amt_q;
  logic               coin_reject_q;
  logic               led_green_q;
  logic               led_yellow_q;

  logic [SUM_W-1:0]   price_tbl [N_PROD];
  logic [SUM_W-1:0]   w_price;
  logic [CALC_W-1:0]  w_sum;
  logic [CALC_W-1:0]  w_total;
  logic               w_coin_ok;
  logic               w_sel_in;
  logic               w_sel_ok;
  logic               w_can_disp;

  // Unpack the flat price parameter into an indexable table.
  genvar gk;
  generate
    for (gk = 0; gk < N_PROD; gk++) begin : g_price
      assign price_tbl[gk] = PRICES[gk*SUM_W +: SUM_W];
    end
  endgenerate

  // Range check of the selection code is only needed when the code space is
  // larger than the product count.
  generate
    if (N_PROD == (1 << SEL_W)) begin : g_sel_all
      assign w_sel_in = 1'b1;
    end else begin : g_sel_chk
      assign w_sel_in = (sel_i < SEL_W'(N_PROD));
    end
  endgenerate

  assign w_price    = price_tbl[sel_q];
  assign w_sum      = CALC_W'(credit_q) + CALC_W'(coin_val_i);
  assign w_coin_ok  = coin_valid_i && (w_sum <= CALC_W'(MAX_CREDIT));
  // Credit including a coin accepted this cycle (if any).
  assign w_total    = w_coin_ok ? w_sum : CALC_W'(credit_q);
  assign w_sel_ok   = sel_valid_i && w_sel_in;
  // Evaluated on registered credit/selection, so a coin or selection seen
  // this cycle only counts on the following cycle.
  assign w_can_disp = sel_vld_q && (credit_q >= w_price);

  // Controller FSM: state, credit, selection and every output are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      sel_q          <= '0;
      sel_vld_q      <= 1'b0;
      disp_req_q     <= 1'b0;
      disp_prod_q    <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      led_green_q    <= 1'b1;
      led_yellow_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;

      case (state_q)
        // IDLE is COLLECT with zero credit and no selection, so both share
        // the coin / selection / cancel handling.
        S_IDLE, S_COLLECT: begin
          coin_reject_q <= coin_valid_i && !w_coin_ok;
          if (cancel_i) begin
            // Cancel wins: refund everything, including a coin taken now.
            change_valid_q <= (w_total != '0);
            change_amt_q   <= SUM_W'(w_total);
            credit_q       <= '0;
            sel_vld_q      <= 1'b0;
            state_q        <= S_IDLE;
            led_green_q    <= 1'b1;
          end else if (w_can_disp) begin
            // Price is taken off on entry; the latched product is frozen
            // for the whole handshake.
            credit_q     <= SUM_W'(w_total) - w_price;
            state_q      <= S_DISPENSE;
            disp_req_q   <= 1'b1;
            disp_prod_q  <= sel_q;
            led_green_q  <= 1'b0;
            led_yellow_q <= 1'b1;
          end else begin
            credit_q <= SUM_W'(w_total);
            if (w_sel_ok) begin
              sel_q     <= sel_i;
              sel_vld_q <= 1'b1;
            end
            if (w_coin_ok || w_sel_ok || (state_q == S_COLLECT)) begin
              state_q     <= S_COLLECT;
              led_green_q <= 1'b0;
            end
          end
        end

        S_DISPENSE: begin
          coin_reject_q <= coin_valid_i;
          if (disp_ack_i) begin
            state_q      <= S_CHANGE;
            disp_req_q   <= 1'b0;
            led_yellow_q <= 1'b0;
          end
        end

        S_CHANGE: begin
          coin_reject_q <= coin_valid_i;
          sel_vld_q     <= 1'b0;
`ifdef VEND_CHANGE_EN
          change_valid_q <= (credit_q != '0);
          change_amt_q   <= credit_q;
          credit_q       <= '0;
          state_q        <= S_IDLE;
          led_green_q    <= 1'b1;
`else
          // Residual credit is carried over towards the next purchase.
          if (credit_q != '0) begin
            state_q     <= S_COLLECT;
            led_green_q <= 1'b0;
          end else begin
            state_q     <= S_IDLE;
            led_green_q <= 1'b1;
          end
`endif
        end

        default: begin
          state_q     <= S_IDLE;
          led_green_q <= 1'b1;
        end
      endcase
    end
  end

  assign disp_req_o     = disp_req_q;
  assign disp_prod_o    = disp_prod_q;
  assign change_valid_o = change_valid_q;
  assign change_amt_o   = change_amt_q;
  assign coin_reject_o  = coin_reject_q;
  assign credit_o       = credit_q;
  assign led_green_o    = led_green_q;
  assign led_yellow_o   = led_yellow_q;

endmodule
`default_nettype wire
